vrf_wb_arbiter: RTL

- Shares the single write port of the 32 x 256-bit SIMD vector register file between several write-back sources (ALU lanes, load unit, FIR accumulator drain).
- Round-robin arbitration with a valid/ready handshake per requester.
- Registered write-port outputs (`we3`/`a3`/`wd3`) drive the register file directly, one write per cycle maximum.
- Sits between the execute/memory stages and the register file write port.

---
 rtl/vrf_wb_arbiter_pkg.sv | 13 +
 rtl/vrf_wb_arbiter_rr_arbiter.sv | 31 +++
 rtl/vrf_wb_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/vrf_wb_arbiter_pkg.sv
// Shared widths and the write-request record for the vector register file write-back path.
package vrf_pkg;

  localparam int VRF_DATA_W   = 256;
  localparam int VRF_ADDR_W   = 5;
  localparam int VRF_NUM_REGS = 32;

  typedef struct packed {
    logic [VRF_ADDR_W-1:0] addr;
    logic [VRF_DATA_W-1:0] data;
  } vrf_wr_req_t;

endpackage

// File: rtl/vrf_wb_arbiter_rr_arbiter.sv
// Round-robin grant: scans req_i upward from ptr_i (wrapping) and grants the first set bit.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o
);

  int idx;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_o[idx]  = 1'b1;
        gnt_idx_o   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/vrf_wb_arbiter.sv
// Round-robin write-back arbiter driving the single VRF write port (we3/a3/wd3).
// Optional busy bitmap of reserved destinations is built when VRF_WB_SCOREBOARD_EN is defined.
module vrf_wb_arbiter
  import vrf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = VRF_DATA_W,
  parameter int ADDR_W  = VRF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      we3,
  output logic [ADDR_W-1:0]         a3,
  output logic [DATA_W-1:0]         wd3,
  input  logic                      rsv_valid,
  input  logic [ADDR_W-1:0]         rsv_addr,
  output logic [(2**ADDR_W)-1:0]    busy
);

  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NUM_REGS = 2**ADDR_W;

  logic [IDX_W-1:0]   ptr_q, ptr_d, gnt_idx;
  logic [NUM_REQ-1:0] req_masked, gnt;
  logic               gnt_valid, hs;
  logic [ADDR_W-1:0]  sel_addr, a3_q, a3_d;
  logic [DATA_W-1:0]  sel_data, wd3_q, wd3_d;
  logic               we3_q, we3_d;

  // Handshake: req_ready is a one-hot grant; a write is taken on a cycle where
  // req_valid[i] & req_ready[i]; the requester holds addr/data until then.
  assign req_masked = stall ? '0 : req_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i       (req_masked),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  assign req_ready = rst ? gnt : '0;
  assign hs        = rst & gnt_valid;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // r0 writes are consumed (pointer moves) but never reach the register file.
  always_comb begin
    we3_d = hs && (sel_addr != '0);
    a3_d  = we3_d ? sel_addr : a3_q;
    wd3_d = we3_d ? sel_data : wd3_q;
    ptr_d = ptr_q;
    if (hs) ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we3_q <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
      ptr_q <= '0;
    end else begin
      we3_q <= we3_d;
      a3_q  <= a3_d;
      wd3_q <= wd3_d;
      ptr_q <= ptr_d;
    end
  end

  assign we3 = we3_q;
  assign a3  = a3_q;
  assign wd3 = wd3_q;

`ifdef VRF_WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Clear for the write leaving the port this edge; a same-address reserve wins.
  always_comb begin
    busy_d = busy_q;
    if (we3_q) busy_d[a3_q] = 1'b0;
    if (rsv_valid && (rsv_addr != '0)) busy_d[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign busy = busy_q;
`else
  logic unused_rsv;
  assign unused_rsv = ^{rsv_valid, rsv_addr};
  assign busy       = '0;
`endif

endmodule
